// File: rtl/pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for pio_out_pulse: word address, select, write strobe and data paths.
interface pio_out_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_out_pulse.sv
// Output PIO with set/clear registers and a one-shot timed pulse overlay that raises a
// maskable done interrupt when the pulse expires.
module pio_out_pulse #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    pio_out_pulse_if.slave    bus,
    output logic              irq,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrIrqMask  = 3'd2;
    localparam logic [2:0] AddrStatus   = 3'd3;
    localparam logic [2:0] AddrOutSet   = 3'd4;
    localparam logic [2:0] AddrOutClr   = 3'd5;
    localparam logic [2:0] AddrPulseLen = 3'd6;
    localparam logic [2:0] AddrPulse    = 3'd7;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   pulse_mask_q, pulse_mask_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   pulse_len_q, pulse_len_d;
    logic               irq_mask_q, irq_mask_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic [31:0]        readdata_q, readdata_d;

    logic               wr_en;
    logic               pulse_wr;
    logic               status_wr;
    logic               pulse_done;
    logic               overrun_set;
    logic               busy;
    logic [WIDTH-1:0]   wdata;
    logic [LEN_W-1:0]   len_load;
    logic               unused_wdata;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign pulse_wr  = wr_en && (bus.address == AddrPulse);
    assign status_wr = wr_en && (bus.address == AddrStatus);
    assign wdata     = bus.writedata[WIDTH-1:0];
    assign busy      = (state_q == StBusy);

    // Upper write-data bits are only meaningful for some registers.
    assign unused_wdata = ^bus.writedata;

    // A programmed length of zero still yields a single-cycle pulse.
    assign len_load = (pulse_len_q == '0) ? LEN_W'(1) : pulse_len_q;

    // Register file: DATA, OUTSET/OUTCLEAR, IRQ_MASK and PULSE_LEN.
    always_comb begin
        data_d      = data_q;
        irq_mask_d  = irq_mask_q;
        pulse_len_d = pulse_len_q;
        if (wr_en) begin
            case (bus.address)
                AddrData:     data_d      = wdata;
                AddrIrqMask:  irq_mask_d  = bus.writedata[0];
                AddrOutSet:   data_d      = data_q | wdata;
                AddrOutClr:   data_d      = data_q & ~wdata;
                AddrPulseLen: pulse_len_d = bus.writedata[LEN_W-1:0];
                default:      ;
            endcase
        end
    end

    // Pulse FSM: a load in idle arms the counter; the busy state runs exactly len_load cycles.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pulse_mask_d = pulse_mask_q;
        pulse_done   = 1'b0;
        overrun_set  = 1'b0;
        case (state_q)
            StIdle: begin
                if (pulse_wr) begin
                    pulse_mask_d = wdata;
                    cnt_d        = len_load;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (pulse_wr) begin
                    overrun_set = 1'b1;
                end
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d    = StIdle;
                    pulse_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky status: a hardware set in the same cycle as a software clear wins.
    always_comb begin
        done_d    = done_q;
        overrun_d = overrun_q;
        if (status_wr) begin
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end
        if (pulse_done) begin
            done_d = 1'b1;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    // Read mux is sampled every cycle regardless of chipselect; write-only words read zero.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            AddrData:     readdata_d[WIDTH-1:0] = data_q;
            AddrIrqMask:  readdata_d[0]         = irq_mask_q;
            AddrStatus:   readdata_d[2:0]       = {overrun_q, done_q, busy};
            AddrPulseLen: readdata_d[LEN_W-1:0] = pulse_len_q;
            AddrPulse:    readdata_d[WIDTH-1:0] = pulse_mask_q;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            data_q       <= '0;
            pulse_mask_q <= '0;
            cnt_q        <= '0;
            pulse_len_q  <= LEN_W'(1);
            irq_mask_q   <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            readdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            pulse_mask_q <= pulse_mask_d;
            cnt_q        <= cnt_d;
            pulse_len_q  <= pulse_len_d;
            irq_mask_q   <= irq_mask_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            readdata_q   <= readdata_d;
        end
    end

    // Single OR stage straight from flops keeps the pins glitch-free.
    assign out_port     = data_q | (pulse_mask_q & {WIDTH{busy}});
    assign irq          = done_q & irq_mask_q;
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed and randomized bench for pio_out_pulse against a time-based behavioural model.
module tb_pio_out_pulse;
    localparam int WIDTH = 18;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             irq;
    logic [WIDTH-1:0] out_port;

    pio_out_pulse_if bus ();

    pio_out_pulse #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .irq      (irq),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: the pulse is an interval of cycle numbers [start, p_end); cyc counts clock edges.
    longint           cyc = 0;
    longint           p_end = 0;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    logic [LEN_W-1:0] m_len;
    logic             m_irqm;
    logic             m_done;
    logic             m_ovr;
    logic [31:0]      m_rd;

    function automatic logic busy_at(longint c);
        return c < p_end;
    endfunction

    function automatic logic [31:0] reg_val(logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v[WIDTH-1:0] = m_data;
            3'd2: v[0] = m_irqm;
            3'd3: v[2:0] = {m_ovr, m_done, busy_at(cyc)};
            3'd6: v[LEN_W-1:0] = m_len;
            3'd7: v[WIDTH-1:0] = m_mask;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_out();
        logic [31:0] v;
        v = '0;
        v[WIDTH-1:0] = m_data | (busy_at(cyc) ? m_mask : '0);
        return v;
    endfunction

    task automatic model_reset();
        m_data = '0;
        m_mask = '0;
        m_len  = LEN_W'(1);
        m_irqm = 1'b0;
        m_done = 1'b0;
        m_ovr  = 1'b0;
        m_rd   = '0;
        p_end  = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        logic        wr;
        logic [2:0]  a;
        logic [31:0] wd;
        logic [31:0] rd_exp;
        logic        busy_pre;
        longint      n;
        wr       = bus.chipselect && !bus.write_n;
        a        = bus.address;
        wd       = bus.writedata;
        rd_exp   = reg_val(a);
        busy_pre = busy_at(cyc);
        @(posedge clk);
        #1;
        if (reset_n) begin
            if (wr) begin
                case (a)
                    3'd0: m_data = wd[WIDTH-1:0];
                    3'd2: m_irqm = wd[0];
                    3'd3: begin m_done = 1'b0; m_ovr = 1'b0; end
                    3'd4: m_data = m_data | wd[WIDTH-1:0];
                    3'd5: m_data = m_data & ~wd[WIDTH-1:0];
                    3'd6: m_len = wd[LEN_W-1:0];
                    3'd7: begin
                        if (busy_pre) m_ovr = 1'b1;
                        else begin
                            n      = (m_len == '0) ? 1 : longint'(m_len);
                            m_mask = wd[WIDTH-1:0];
                            p_end  = cyc + 1 + n;
                        end
                    end
                    default: ;
                endcase
            end
            if (busy_pre && (cyc + 1 == p_end)) m_done = 1'b1;
            m_rd = rd_exp;
        end
        cyc++;
        check("out_port", {14'd0, out_port}, exp_out());
        check("irq", {31'd0, irq}, {31'd0, m_done & m_irqm});
        check("readdata", bus.readdata, m_rd);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        bus.address    = 3'd0;
        bus.writedata  = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset_n        = 1'b0;
        model_reset();
        #2;
        check("rst_out_port", {14'd0, out_port}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        bus.address = 3'd6;
        tick();
        check("rst_pulse_len", bus.readdata, 32'h1);

        // DATA, OUTSET, OUTCLEAR
        wr(3'd0, 32'h155);
        wr(3'd4, 32'h00A);
        wr(3'd5, 32'h100);
        check("setclr_out", {14'd0, out_port}, 32'h05F);
        bus.address = 3'd0;
        tick();
        check("setclr_read", bus.readdata, 32'h0000_005F);

        // 5-cycle pulse with interrupt
        wr(3'd0, 32'h0);
        wr(3'd6, 32'd5);
        wr(3'd2, 32'h1);
        wr(3'd7, 32'h3);
        for (int i = 0; i < 5; i++) begin
            check("len5_pulse", {14'd0, out_port}, 32'h3);
            tick();
        end
        check("len5_end", {14'd0, out_port}, 32'h0);
        bus.address = 3'd3;
        tick();
        check("len5_status", bus.readdata, 32'h2);
        check("len5_irq", {31'd0, irq}, 32'h1);
        wr(3'd3, 32'h0);
        check("len5_irq_clr", {31'd0, irq}, 32'h0);

        // zero length behaves as one cycle
        wr(3'd6, 32'd0);
        wr(3'd7, 32'h1);
        check("len0_pulse", {14'd0, out_port}, 32'h1);
        tick();
        check("len0_end", {14'd0, out_port}, 32'h0);
        bus.address = 3'd3;
        tick();
        check("len0_status", bus.readdata, 32'h2);

        // overrun and deferred length
        wr(3'd3, 32'h0);
        wr(3'd6, 32'd10);
        wr(3'd7, 32'h1);
        check("ovr_c1", {14'd0, out_port}, 32'h1);
        wr(3'd7, 32'h2);
        check("ovr_c2", {14'd0, out_port}, 32'h1);
        wr(3'd6, 32'd3);
        check("ovr_c3", {14'd0, out_port}, 32'h1);
        for (int i = 3; i < 10; i++) begin
            tick();
            check("ovr_run", {14'd0, out_port}, 32'h1);
        end
        tick();
        check("ovr_end", {14'd0, out_port}, 32'h0);
        bus.address = 3'd3;
        tick();
        check("ovr_status", bus.readdata, 32'h6);
        wr(3'd7, 32'h4);
        for (int i = 0; i < 3; i++) begin
            check("len3_pulse", {14'd0, out_port}, 32'h4);
            tick();
        end
        check("len3_end", {14'd0, out_port}, 32'h0);

        // pulse end coincides with STATUS clear
        wr(3'd3, 32'h0);
        wr(3'd6, 32'd2);
        wr(3'd7, 32'h1);
        tick();
        wr(3'd3, 32'h0);
        bus.address = 3'd3;
        tick();
        check("race_status", bus.readdata, 32'h2);

        // asynchronous reset mid-pulse
        wr(3'd3, 32'h0);
        wr(3'd6, 32'd10);
        wr(3'd7, 32'h1);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_out", {14'd0, out_port}, 32'h0);
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        bus.address = 3'd6;
        tick();
        check("mid_rst_len", bus.readdata, 32'h1);
        bus.address = 3'd3;
        repeat (12) tick();
        check("mid_rst_status", bus.readdata, 32'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.address    = 3'($urandom_range(0, 7));
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write_n    = ($urandom_range(0, 2) != 0);
            bus.writedata  = $urandom;
            if (bus.address == 3'd6) bus.writedata = bus.writedata & 32'h7;
            tick();
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pio_out_pulse.md
PIO_OUT_PULSE -- requirements
Module: pio_out_pulse

Interface
REQ-001 SHALL have parameter WIDTH, default 18, meaning output port width (1..32).
REQ-002 SHALL have parameter LEN_W, default 16, meaning pulse-length counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port address  input  3  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  registered read data.
REQ-010 SHALL have port irq  output  1  pulse-done interrupt.
REQ-011 SHALL have port out_port  output  WIDTH  driven output pins.

Function
REQ-012 A write SHALL occur when chipselect=1 and write_n=0; zero wait states.
REQ-013 Register map SHALL be: 0 DATA (R/W), 1 reserved (reads 0, writes ignored), 2 IRQ_MASK bit0 (R/W), 3 STATUS (bit0 busy, bit1 done, bit2 overrun; R, any write clears done and overrun), 4 OUTSET (W, reads 0), 5 OUTCLEAR (W, reads 0), 6 PULSE_LEN (R/W, LEN_W bits), 7 PULSE (W, reads current pulse mask).
REQ-014 readdata SHALL update every cycle with the addressed value, zero-extended, valid the cycle after address is presented (1-cycle latency).
REQ-015 OUTSET write SHALL set DATA <= DATA | writedata[WIDTH-1:0]; OUTCLEAR write SHALL set DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-016 out_port SHALL equal DATA | (busy ? pulse_mask : 0), combinational from registers, no glitch-causing logic beyond one OR stage.
REQ-017 Pulse FSM SHALL have states IDLE and BUSY; busy flag = (state==BUSY).
REQ-018 In IDLE, a PULSE write SHALL load pulse_mask <= writedata[WIDTH-1:0], counter <= PULSE_LEN (value 0 treated as 1), and enter BUSY at the same edge.
REQ-019 In BUSY the counter SHALL decrement each cycle; at the edge where counter==1 the FSM SHALL return to IDLE and set done=1, giving exactly PULSE_LEN cycles of pulse_mask on out_port.
REQ-020 A PULSE write while BUSY SHALL be ignored and SHALL set overrun=1; running pulse unaffected.
REQ-021 A PULSE_LEN write while BUSY SHALL affect only the next pulse.
REQ-022 A PULSE write with mask 0 SHALL still run the full FSM sequence and set done.
REQ-023 If done is set and a STATUS write occurs in the same cycle, set SHALL win (done=1); same for overrun.
REQ-024 irq SHALL equal done & IRQ_MASK[0], combinational.
REQ-025 DATA writes during BUSY SHALL take effect immediately; bits in both DATA and pulse_mask stay 1 after the pulse ends.

Reset
REQ-026 On reset_n=0, asynchronously: DATA=0, IRQ_MASK=0, done=0, overrun=0, state=IDLE, pulse_mask=0, counter=0, PULSE_LEN=1, readdata=0; hence out_port=0, irq=0.
REQ-027 Reset asserted mid-pulse SHALL abort the pulse with no done set after release.

Verification
REQ-028 Write DATA=0x155, OUTSET 0x00A, OUTCLEAR 0x100 -> out_port=0x05F; read addr 0 returns 0x0000005F one cycle later.
REQ-029 PULSE_LEN=5, IRQ_MASK=1, PULSE 0x3 with DATA=0 -> out_port=0x3 for exactly 5 cycles starting cycle after write, then 0; STATUS=0x2, irq=1; STATUS write -> irq=0.
REQ-030 PULSE_LEN=0, PULSE 0x1 -> out_port=0x1 for exactly 1 cycle, done=1.
REQ-031 During 10-cycle pulse of 0x1, write PULSE 0x2 and PULSE_LEN=3 -> out_port stays 0x1 for full 10 cycles, overrun=1; next PULSE lasts 3 cycles.
REQ-032 Pulse ending in same cycle as STATUS write -> done=1 afterwards.
REQ-033 Assert reset_n at cycle 3 of a 10-cycle pulse -> out_port=0 immediately, busy=0, done=0, PULSE_LEN reads 1 after release.
